// File: rtl/dm_lsu.sv
// Data memory with integrated load/store unit: req/busy/ready handshake, configurable wait
// states, sub-word store merge, sign/zero-extended loads and fault flagging.
module dm_lsu #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 0,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] wpc,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        exc
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, wpc_q, wpc_d;
  logic        busy_q, busy_d, ready_q, ready_d, exc_q, exc_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic [AW-1:0] idx_s;
  logic [31:0]   word_s, merged_s, load_s;
  logic [15:0]   half_s;
  logic [7:0]    byte_s;
  logic          fault_s, commit_s, wr_en_s;

  assign idx_s  = addr_q[AW+1:2];
  assign word_s = mem_q[idx_s];

  // Fault detection, lane selection, store merge and load extension on the captured request
  always_comb begin
    fault_s = ((op_q[1:0] == 2'b01) && addr_q[0])
            || ((op_q[1:0] == 2'b00) && (addr_q[1:0] != 2'b00))
            || ((addr_q >> (AW + 2)) != 32'd0)
            || (op_q[1:0] == 2'b11);
    if (addr_q[1]) begin
      half_s = word_s[31:16];
    end else begin
      half_s = word_s[15:0];
    end
    merged_s = word_s;
    case (addr_q[1:0])
      2'b00:   begin byte_s = word_s[7:0];   merged_s[7:0]   = wdata_q[7:0]; end
      2'b01:   begin byte_s = word_s[15:8];  merged_s[15:8]  = wdata_q[7:0]; end
      2'b10:   begin byte_s = word_s[23:16]; merged_s[23:16] = wdata_q[7:0]; end
      default: begin byte_s = word_s[31:24]; merged_s[31:24] = wdata_q[7:0]; end
    endcase
    case (op_q[1:0])
      2'b00: begin
        merged_s = wdata_q;
        load_s   = word_s;
      end
      2'b01: begin
        if (addr_q[1]) begin
          merged_s = {wdata_q[15:0], word_s[15:0]};
        end else begin
          merged_s = {word_s[31:16], wdata_q[15:0]};
        end
        load_s = op_q[2] ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
      end
      2'b10: begin
        load_s = op_q[2] ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
      end
      default: begin
        load_s = 32'd0;
      end
    endcase
  end

  assign commit_s = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign wr_en_s  = commit_s && we_q && !fault_s;

  // Handshake FSM next-state and registered response values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wpc_d   = wpc_q;
    busy_d  = busy_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          op_d    = op;
          addr_d  = addr;
          wdata_d = wdata;
          wpc_d   = wpc;
          cnt_d   = 4'(LATENCY);
          busy_d  = 1'b1;
          state_d = S_WAIT;
        end else begin
          busy_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ready_d = 1'b1;
          exc_d   = fault_s;
          rdata_d = (fault_s || we_q) ? 32'd0 : load_s;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, memory and write log; reset drops any in-flight request
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      op_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wpc_q   <= 32'd0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      exc_q   <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wpc_q   <= wpc_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
      if (wr_en_s) begin
        mem_q[idx_s] <= merged_s;
        $display("%d@%h: *%h <= %h", $time, wpc_q, {addr_q[31:2], 2'b00}, merged_s);
      end
    end
  end

  assign busy  = busy_q;
  assign ready = ready_q;
  assign rdata = rdata_q;
  assign exc   = exc_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu: three instances with LATENCY 0, 3 and 4 share the request
// fields; each has its own req and Reset.
module tb_dm_lsu;

  logic        clk = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] addr_i = 32'd0, wdata_i = 32'd0, wpc_i = 32'h0040_0000;
  logic        req0 = 1'b0, req3 = 1'b0, req4 = 1'b0;
  logic        rst0 = 1'b1, rst3 = 1'b1, rst4 = 1'b1;
  logic        busy0, busy3, busy4, ready0, ready3, ready4, exc0, exc3, exc4;
  logic [31:0] rdata0, rdata3, rdata4;
  logic        busy_m, ready_m, exc_m;
  logic [31:0] rdata_m;
  int          sel = 0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dm_lsu #(.DEPTH_WORDS(4096), .LATENCY(0)) u0 (
    .Clk(clk), .Reset(rst0), .req(req0), .we(we_i), .op(op_i), .addr(addr_i),
    .wdata(wdata_i), .wpc(wpc_i), .busy(busy0), .ready(ready0), .rdata(rdata0), .exc(exc0));
  dm_lsu #(.DEPTH_WORDS(4096), .LATENCY(3)) u3 (
    .Clk(clk), .Reset(rst3), .req(req3), .we(we_i), .op(op_i), .addr(addr_i),
    .wdata(wdata_i), .wpc(wpc_i), .busy(busy3), .ready(ready3), .rdata(rdata3), .exc(exc3));
  dm_lsu #(.DEPTH_WORDS(4096), .LATENCY(4)) u4 (
    .Clk(clk), .Reset(rst4), .req(req4), .we(we_i), .op(op_i), .addr(addr_i),
    .wdata(wdata_i), .wpc(wpc_i), .busy(busy4), .ready(ready4), .rdata(rdata4), .exc(exc4));

  always_comb begin
    case (sel)
      3:       begin busy_m = busy3; ready_m = ready3; rdata_m = rdata3; exc_m = exc3; end
      4:       begin busy_m = busy4; ready_m = ready4; rdata_m = rdata4; exc_m = exc4; end
      default: begin busy_m = busy0; ready_m = ready0; rdata_m = rdata0; exc_m = exc0; end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int s, input logic v);
    case (s)
      3:       req3 = v;
      4:       req4 = v;
      default: req0 = v;
    endcase
  endtask

  // One request on instance s (s equals its LATENCY); inputs are scrambled after accept and,
  // with hold set, req stays high through WAIT/RESP.
  task automatic xfer(input string tag, input int s, input logic w, input logic [2:0] o,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd,
                      input logic exp_ex, input logic hold);
    int lat;
    sel = s;
    @(negedge clk);
    we_i = w; op_i = o; addr_i = a; wdata_i = d; wpc_i = wpc_i + 32'd4;
    set_req(s, 1'b1);
    @(posedge clk);
    #1;
    if (!hold) set_req(s, 1'b0);
    we_i = ~w; op_i = 3'b010; addr_i = 32'h0000_0024; wdata_i = 32'hbad0_bad0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready_m && lat < 40);
    chk({tag, "_lat"}, 32'(lat), 32'(s + 2));
    chk({tag, "_rdata"}, rdata_m, exp_rd);
    chk({tag, "_exc"}, {31'd0, exc_m}, {31'd0, exp_ex});
    chk({tag, "_busy_resp"}, {31'd0, busy_m}, 32'd1);
    set_req(s, 1'b0);
    @(negedge clk);
    chk({tag, "_ready_drop"}, {31'd0, ready_m}, 32'd0);
    chk({tag, "_busy_drop"}, {31'd0, busy_m}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc [$];
    int k;
    logic prev_b;
    logic seen_ready;

    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_ready", {31'd0, ready0}, 32'd0);
    chk("rst_rdata", rdata0, 32'd0);
    chk("rst_exc", {31'd0, exc0}, 32'd0);

    // Word store/load, then sub-word merges and extensions (LATENCY 0)
    xfer("sw10", 0, 1'b1, 3'b000, 32'h10, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    xfer("lw10", 0, 1'b0, 3'b000, 32'h10, 32'd0, 32'h1234_5678, 1'b0, 1'b0);
    xfer("sb13", 0, 1'b1, 3'b010, 32'h13, 32'h0000_00ab, 32'd0, 1'b0, 1'b0);
    xfer("lw_after_sb", 0, 1'b0, 3'b000, 32'h10, 32'd0, 32'hab34_5678, 1'b0, 1'b0);
    xfer("sh10", 0, 1'b1, 3'b001, 32'h10, 32'h0000_cdef, 32'd0, 1'b0, 1'b0);
    xfer("lw_after_sh", 0, 1'b0, 3'b000, 32'h10, 32'd0, 32'hab34_cdef, 1'b0, 1'b0);
    xfer("lb13", 0, 1'b0, 3'b010, 32'h13, 32'd0, 32'hffff_ffab, 1'b0, 1'b0);
    xfer("lbu13", 0, 1'b0, 3'b110, 32'h13, 32'd0, 32'h0000_00ab, 1'b0, 1'b0);
    xfer("lb11", 0, 1'b0, 3'b010, 32'h11, 32'd0, 32'hffff_ffcd, 1'b0, 1'b0);
    xfer("lbu12", 0, 1'b0, 3'b110, 32'h12, 32'd0, 32'h0000_0034, 1'b0, 1'b0);
    xfer("lh10", 0, 1'b0, 3'b001, 32'h10, 32'd0, 32'hffff_cdef, 1'b0, 1'b0);
    xfer("lhu12", 0, 1'b0, 3'b101, 32'h12, 32'd0, 32'h0000_ab34, 1'b0, 1'b0);

    // Faults: no write, rdata cleared, exc set
    xfer("f_lw12", 0, 1'b0, 3'b000, 32'h12, 32'd0, 32'd0, 1'b1, 1'b0);
    xfer("f_sh11", 0, 1'b1, 3'b001, 32'h11, 32'h0000_9999, 32'd0, 1'b1, 1'b0);
    xfer("f_sb4000", 0, 1'b1, 3'b010, 32'h4000, 32'h0000_0077, 32'd0, 1'b1, 1'b0);
    xfer("f_op011", 0, 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1, 1'b0);
    xfer("lw10_post_fault", 0, 1'b0, 3'b000, 32'h10, 32'd0, 32'hab34_cdef, 1'b0, 1'b0);
    xfer("lw0_post_fault", 0, 1'b0, 3'b000, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);

    // LATENCY 3 with req held through busy and inputs changed after accept
    xfer("l3_sw20", 3, 1'b1, 3'b000, 32'h20, 32'hdead_beef, 32'd0, 1'b0, 1'b1);
    xfer("l3_lw20", 3, 1'b0, 3'b000, 32'h20, 32'd0, 32'hdead_beef, 1'b0, 1'b1);
    xfer("l3_lw24", 3, 1'b0, 3'b000, 32'h24, 32'd0, 32'd0, 1'b0, 1'b0);

    // Back-to-back: req held high, accepts every LATENCY+3 cycles
    @(negedge clk);
    we_i = 1'b1; op_i = 3'b000; addr_i = 32'h30; wdata_i = 32'h1234_abcd;
    req3 = 1'b1;
    prev_b = busy3;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (busy3 && !prev_b) acc.push_back(c);
      prev_b = busy3;
    end
    req3 = 1'b0;
    chk("b2b_accepts", 32'(acc.size()), 32'd5);
    for (int i = 1; i < acc.size(); i++) chk("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd6);
    k = 0;
    while (busy3 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("b2b_drain", {31'd0, busy3}, 32'd0);
    xfer("b2b_lw30", 3, 1'b0, 3'b000, 32'h30, 32'd0, 32'h1234_abcd, 1'b0, 1'b0);

    // Reset during WAIT of a store (LATENCY 4)
    xfer("l4_sw20", 4, 1'b1, 3'b000, 32'h20, 32'h0000_0055, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    we_i = 1'b1; op_i = 3'b000; addr_i = 32'h20; wdata_i = 32'h0000_0099;
    req4 = 1'b1;
    @(posedge clk);
    #1 req4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("l4_busy_wait", {31'd0, busy4}, 32'd1);
    rst4 = 1'b1;
    @(posedge clk);
    #1 rst4 = 1'b0;
    @(negedge clk);
    chk("l4_rst_busy", {31'd0, busy4}, 32'd0);
    chk("l4_rst_ready", {31'd0, ready4}, 32'd0);
    seen_ready = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ready4 || busy4) seen_ready = 1'b1;
    end
    chk("l4_no_resp", {31'd0, seen_ready}, 32'd0);
    xfer("l4_lw20", 4, 1'b0, 3'b000, 32'h20, 32'd0, 32'd0, 1'b0, 1'b0);

    // Reset and req at the same edge: request dropped, memory cleared
    @(negedge clk);
    we_i = 1'b0; op_i = 3'b000; addr_i = 32'h10;
    rst0 = 1'b1; req0 = 1'b1;
    @(posedge clk);
    #1 begin rst0 = 1'b0; req0 = 1'b0; end
    @(negedge clk);
    chk("rst_req_busy", {31'd0, busy0}, 32'd0);
    xfer("lw10_after_rst", 0, 1'b0, 3'b000, 32'h10, 32'd0, 32'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_lsu.md
# dm_lsu

Parametrised data memory with an integrated load/store unit for the pipelined MIPS core. It accepts one request at a time over a req/busy/ready handshake, models configurable wait states, and merges sub-word stores into the containing word. It also sign- or zero-extends sub-word loads and flags misaligned or out-of-range accesses without touching memory. It sits in the MEM stage and replaces the fixed-latency word memory.

## Interface
- DEPTH_WORDS, 4096: number of 32-bit words; power of two.
- AW, log2(DEPTH_WORDS): word-index width, derived, not overridden.
- LATENCY, 0: extra wait cycles per request, 0..15.
- Clk  in  1  clock, all state updates on posedge.
- Reset  in  1  synchronous, active-high; clears memory and control state.
- req  in  1  request valid; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- op  in  3  op[1:0] size: 00 word, 01 half, 10 byte, 11 illegal. op[2] = 1 unsigned load (lbu/lhu); ignored for stores.
- addr  in  32  byte address.
- wdata  in  32  store data, low-aligned (byte in [7:0], half in [15:0]).
- wpc  in  32  PC of the issuing instruction, for the write log.
- busy  out  1  high from the acceptance edge until the response cycle ends.
- ready  out  1  one-cycle response pulse.
- rdata  out  32  extended load result; held until the next response.
- exc  out  1  request faulted (misaligned, out of range, or illegal size); held until the next response.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: when req = 1, capture we, op, addr, wdata, wpc; load cnt = LATENCY; go to WAIT.
  - WAIT: while cnt != 0, decrement. When cnt == 0 at an edge, commit (below) and go to RESP.
  - RESP: ready = 1 for exactly this cycle; next state IDLE. req is ignored in WAIT and RESP.
- Fault check on captured request:
  - Misaligned: half with addr[0] = 1, or word with addr[1:0] != 00.
  - Out of range: addr[31:AW+2] != 0.
  - Illegal size: op[1:0] = 11.
  - On a fault: exc = 1, rdata = 0, no memory write, no log line. The response still occurs on the normal schedule.
- Store commit (no fault): read word W = mem[addr[AW+1:2]], merge, write back.
  - word: W' = wdata.
  - half: the lane selected by addr[1] gets wdata[15:0].
  - byte: the lane selected by addr[1:0] gets wdata[7:0]; lane 0 is bits [7:0].
  - Untouched lanes keep W.
  - Log exactly once at the commit edge with $display("%d@%h: *%h <= %h", $time, wpc, {addr[31:2],2'b00}, W').
  - rdata = 0, exc = 0.
- Load commit (no fault): select the lane the same way as stores.
  - Sign-extend when op[2] = 0; zero-extend when op[2] = 1. Word loads are passed through unchanged.
  - exc = 0.
- Memory array is only written at commit edges and at Reset.

## Timing
- Acceptance edge E0. The commit happens at edge E(1+LATENCY). ready is high in the cycle after that edge.
  - LATENCY = 0: ready is high in the 2nd cycle after req was sampled.
  - Minimum request spacing is LATENCY+3 cycles.
- busy rises at E0 and falls at the edge that ends RESP. busy and ready are both high during RESP.
- A store written at commit is visible to a load accepted any time after that RESP.
- Reset at any edge, including mid-WAIT:
  - state = IDLE; busy = 0, ready = 0, rdata = 0, exc = 0.
  - All words cleared to 0.
  - Any pending request is dropped: no write, no log line, no ready.
- If Reset and req are high at the same edge, Reset wins and the request is not accepted.
- Input changes after E0 have no effect on the in-flight request.

## Test plan
- Reset, then word store to 0x10 of 0x12345678, then lw 0x10.
  - Store: log "*00000010 <= 12345678".
  - Load: rdata = 0x12345678, exc = 0, ready one cycle, 2 cycles after accept (LATENCY = 0).
- From word 0x12345678 at 0x10:
  - sb 0xAB to 0x13: log "*00000010 <= ab345678".
  - sh 0xCDEF to 0x10: word becomes 0xab34cdef.
  - lb 0x13 returns 0xffffffab; lbu 0x13 returns 0x000000ab; lh 0x10 returns 0xffffcdef; lhu 0x12 returns 0x0000ab34.
- Faults each give exc = 1, rdata = 0, no log, memory unchanged:
  - lw at 0x12; sh at 0x11; sb at addr 0x4000 (DEPTH_WORDS = 4096); op = 011.
- LATENCY = 3:
  - ready arrives exactly 5 cycles after the acceptance cycle.
  - req pulses during busy are ignored.
  - Changing addr/wdata after accept does not alter the committed data.
- Assert Reset during WAIT of a store (LATENCY = 4):
  - No log, busy/ready drop next cycle.
  - A subsequent lw of that address returns 0.
- Back-to-back requests: req held high continuously.
  - Accepts occur every LATENCY+3 cycles.
  - Each store produces exactly one log line.
